// File: rtl/fifo_burst_reader.sv
// +----------------------------------------------------------------------------+
// | fifo_burst_reader: drains BURST_LEN words from the write-data FIFO, then     |
// | requests an SDRAM write burst and streams the words out.  Rev 1.0          |
// +----------------------------------------------------------------------------+
`default_nettype none

module fifo_burst_reader #(
  parameter int WIDTH      = 8,
  parameter int BURST_LEN  = 4,
  parameter int CNT_SIZE   = 2,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [WIDTH-1:0]      fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  bst_req,
  output logic [ADDR_WIDTH-1:0] bst_addr,
  input  logic                  bst_ack,
  output logic                  bst_valid,
  output logic [WIDTH-1:0]      bst_data,
  output logic                  bst_last,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_REQ   = 2'd2,
    S_SEND  = 2'd3
  } state_t;

  localparam logic [CNT_SIZE:0]     C_BURST_CNT = (CNT_SIZE+1)'(BURST_LEN);
  localparam logic [CNT_SIZE:0]     C_LAST_CAP  = (CNT_SIZE+1)'(BURST_LEN - 1);
  localparam logic [CNT_SIZE:0]     C_CNT_ONE   = (CNT_SIZE+1)'(1);
  localparam logic [CNT_SIZE-1:0]   C_LAST_IDX  = CNT_SIZE'(BURST_LEN - 1);
  localparam logic [CNT_SIZE-1:0]   C_IDX_ONE   = CNT_SIZE'(1);
  localparam logic [ADDR_WIDTH-1:0] C_ADDR_STEP = ADDR_WIDTH'(BURST_LEN);

  state_t                  state_q, state_d;
  logic [CNT_SIZE:0]       pop_cnt_q, pop_cnt_d;
  logic [CNT_SIZE:0]       cap_cnt_q, cap_cnt_d;
  logic                    pop_d1_q, pop_d1_d;
  logic [CNT_SIZE-1:0]     idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]        burst_buf_q [BURST_LEN];
  logic [WIDTH-1:0]        burst_buf_d [BURST_LEN];
  logic                    pop;

  // Pop request is combinational on fifo_empty so it can never fire on an empty FIFO.
  assign pop = (state_q == S_FETCH) && !fifo_empty && (pop_cnt_q < C_BURST_CNT);

  always_comb begin
    state_d     = state_q;
    pop_cnt_d   = pop_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    pop_d1_d    = pop;
    idx_d       = idx_q;
    addr_d      = addr_q;
    burst_buf_d = burst_buf_q;

    if (pop) begin
      pop_cnt_d = pop_cnt_q + C_CNT_ONE;
    end
    // Read data lags the accepted pop by one cycle.
    if (pop_d1_q) begin
      burst_buf_d[cap_cnt_q[CNT_SIZE-1:0]] = fifo_rd_data;
      cap_cnt_d = cap_cnt_q + C_CNT_ONE;
    end

    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d   = S_FETCH;
          pop_cnt_d = '0;
          cap_cnt_d = '0;
        end
      end
      S_FETCH: begin
        if (pop_d1_q && (cap_cnt_q == C_LAST_CAP)) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bst_ack) begin
          state_d = S_SEND;
          idx_d   = '0;
        end
      end
      S_SEND: begin
        idx_d = idx_q + C_IDX_ONE;
        if (idx_q == C_LAST_IDX) begin
          idx_d  = '0;
          addr_d = addr_q + C_ADDR_STEP;
          if (en) begin
            state_d   = S_FETCH;
            pop_cnt_d = '0;
            cap_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pop_cnt_q <= '0;
      cap_cnt_q <= '0;
      pop_d1_q  <= 1'b0;
      idx_q     <= '0;
      addr_q    <= '0;
      for (int i = 0; i < BURST_LEN; i++) begin
        burst_buf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pop_cnt_q   <= pop_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      pop_d1_q    <= pop_d1_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      burst_buf_q <= burst_buf_d;
    end
  end

  assign fifo_rd_en = pop;
  assign bst_req    = (state_q == S_REQ);
  assign bst_valid  = (state_q == S_SEND);
  assign bst_last   = (state_q == S_SEND) && (idx_q == C_LAST_IDX);
  assign busy       = (state_q != S_IDLE);
  assign bst_addr   = addr_q;
  assign bst_data   = (state_q == S_SEND) ? burst_buf_q[idx_q] : '0;

endmodule

`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
// +----------------------------------------------------------------------------+
// | tb_fifo_burst_reader: scoreboard bench with FIFO and command-engine models. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fifo_burst_reader;

  localparam int WIDTH = 8;
  localparam int BL    = 4;
  localparam int CS    = 2;
  localparam int AW    = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic            fifo_empty;
  logic [WIDTH-1:0] fifo_rd_data;
  logic            fifo_rd_en;
  logic            bst_req;
  logic [AW-1:0]   bst_addr;
  logic            bst_ack;
  logic            bst_valid;
  logic [WIDTH-1:0] bst_data;
  logic            bst_last;
  logic            busy;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .WIDTH(WIDTH), .BURST_LEN(BL), .CNT_SIZE(CS), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .bst_req(bst_req), .bst_addr(bst_addr), .bst_ack(bst_ack),
    .bst_valid(bst_valid), .bst_data(bst_data), .bst_last(bst_last), .busy(busy)
  );

  // ---------------- FIFO model (contents, optional starvation gap) ----------
  logic [WIDTH-1:0] mem [0:1023];
  int wr_ptr = 0, rd_ptr = 0, pop_num = 0;
  int gap_at = -1, gap_len = 0, gap_left = 0;

  assign fifo_empty = (gap_left > 0) || (rd_ptr == wr_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= wr_ptr;
      gap_left     <= 0;
      fifo_rd_data <= '0;
    end else if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_ptr % 1024];
      rd_ptr       <= rd_ptr + 1;
      pop_num      <= pop_num + 1;
      if (pop_num + 1 == gap_at) gap_left <= gap_len;
    end else if (gap_left > 0) begin
      gap_left <= gap_left - 1;
    end
  end

  // ---------------- command engine model -----------------------------------
  int ack_delay = 0, cur_delay = 0, req_wait = 0;
  initial begin
    bst_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bst_req) begin
        if (req_wait == 0) cur_delay = ack_delay;
        bst_ack = (req_wait >= cur_delay);
        req_wait++;
      end else begin
        req_wait = 0;
        bst_ack  = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- reference model / scoreboard storage --------------------
  logic [WIDTH-1:0] exp_data [0:1023];
  logic             exp_last [0:1023];
  logic [AW-1:0]    exp_addr [0:1023];
  logic [WIDTH-1:0] grp [0:BL-1];
  int exp_wr = 0, gcnt = 0, bnum = 0;
  int exp_fetch_len = -1;
  logic timeout_hit = 1'b0;

  // A burst of BL consecutive FIFO words appears at address bnum*BL (mod 2^AW).
  task automatic push(input logic [WIDTH-1:0] d);
    mem[wr_ptr % 1024] = d;
    wr_ptr++;
    grp[gcnt] = d;
    gcnt++;
    if (gcnt == BL) begin
      for (int k = 0; k < BL; k++) begin
        exp_data[exp_wr] = grp[k];
        exp_last[exp_wr] = (k == BL - 1);
        exp_addr[exp_wr] = AW'((bnum * BL) % (1 << AW));
        exp_wr++;
      end
      bnum++;
      gcnt = 0;
    end
  endtask

  // ---------------- monitor --------------------------------------------------
  int checks = 0, errors = 0;
  int exp_rd = 0, fetch_len = 0, req_len = 0;
  logic prev_req = 0, prev_last = 0, last_en = 0, to_rep = 0;
  logic [AW-1:0] prev_addr = '0, req_addr = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (timeout_hit && !to_rep) begin
      to_rep = 1'b1;
      chk("drain_timeout", 32'd1, 32'd0);
    end
    if (!rst_n) begin
      chk("rst_ctrl", {27'd0, fifo_rd_en, bst_req, bst_valid, bst_last, busy}, 32'd0);
      chk("rst_addr", 32'(bst_addr), 32'd0);
      chk("rst_data", 32'(bst_data), 32'd0);
      exp_rd    = exp_wr;
      prev_req  = 1'b0;
      prev_last = 1'b0;
      fetch_len = 0;
    end else begin
      if (fifo_rd_en) begin
        chk("pop_while_empty", 32'(fifo_empty), 32'd0);
        chk("pop_outside_fetch", 32'(bst_req || bst_valid), 32'd0);
      end
      if (prev_last) begin
        chk("busy_after_last", 32'(busy), 32'(last_en));
        chk("valid_after_last", 32'(bst_valid), 32'd0);
        chk("addr_advance", 32'(bst_addr), 32'(AW'(prev_addr + AW'(BL))));
      end
      if (prev_req && !bst_req) begin
        chk("send_follows_req", 32'(bst_valid), 32'd1);
        chk("req_len", 32'(req_len), 32'(cur_delay + 1));
      end
      if (bst_req) begin
        if (!prev_req) begin
          if (exp_rd < exp_wr) chk("req_addr", 32'(bst_addr), 32'(exp_addr[exp_rd]));
          else chk("req_without_burst", 32'd1, 32'd0);
          if (exp_fetch_len >= 0) chk("fetch_len", 32'(fetch_len), 32'(exp_fetch_len));
          req_addr = bst_addr;
          req_len  = 1;
        end else begin
          chk("req_addr_stable", 32'(bst_addr), 32'(req_addr));
          req_len++;
        end
        fetch_len = 0;
      end
      if (busy && !bst_req && !bst_valid) fetch_len++;
      if (bst_valid) begin
        fetch_len = 0;
        if (exp_rd >= exp_wr) begin
          chk("unexpected_word", 32'd1, 32'd0);
        end else begin
          chk("data", 32'(bst_data), 32'(exp_data[exp_rd]));
          chk("last", 32'(bst_last), 32'(exp_last[exp_rd]));
          chk("send_addr", 32'(bst_addr), 32'(exp_addr[exp_rd]));
          exp_rd++;
        end
      end
      if (bst_last) last_en = en;
      prev_last = bst_last;
      prev_req  = bst_req;
      prev_addr = bst_addr;
    end
  end

  // ---------------- stimulus -------------------------------------------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  // Run until every queued burst has left the DUT and it is back in IDLE;
  // en is dropped during the final burst so the engine parks in IDLE.
  task automatic drain();
    int t;
    for (t = 0; t < 400 && !(exp_rd == exp_wr && !busy); t++) begin
      step();
      if (!busy && exp_rd != exp_wr) en = 1'b1;
      else if (bst_valid && (exp_wr - exp_rd) <= BL) en = 1'b0;
    end
    if (t >= 400) timeout_hit = 1'b1;
    en = 1'b0;
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Single burst from a preloaded FIFO, immediate ack.
    ack_delay = 0; exp_fetch_len = 5;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    drain();

    // Starved FIFO: 5 empty cycles after the second pop.
    gap_at = pop_num + 2; gap_len = 5; exp_fetch_len = 10;
    for (int i = 0; i < BL; i++) push(8'($urandom));
    drain();
    gap_at = -1;

    // Delayed ack: 7 cycles low, req high for 8.
    ack_delay = 7; exp_fetch_len = 5;
    for (int i = 0; i < BL; i++) push(8'($urandom));
    drain();

    // Back-to-back bursts through the address wrap.
    ack_delay = 1;
    for (int i = 0; i < 5 * BL; i++) push(8'($urandom));
    drain();

    // Reset after two captures discards the burst; next burst restarts at 0.
    exp_fetch_len = 5; ack_delay = 0;
    for (int i = 0; i < BL; i++) push(8'($urandom));
    en = 1'b1;
    for (t = 0; t < 20 && !busy; t++) step();
    if (t >= 20) timeout_hit = 1'b1;
    repeat (3) step();
    rst_n = 1'b0; en = 1'b0;
    bnum = 0; gcnt = 0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
    drain();

    // Randomised traffic: concurrent pushes, random ack latency and gaps.
    exp_fetch_len = -1;
    for (int r = 0; r < 8; r++) begin
      int nb;
      ack_delay = $urandom_range(0, 3);
      nb = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) begin
        gap_at  = pop_num + $urandom_range(1, 3);
        gap_len = $urandom_range(1, 4);
      end
      en = 1'b1;
      for (int w = 0; w < nb * BL; w++) begin
        if (w == nb * BL - 1) en = 1'b0;
        push(8'($urandom));
        repeat ($urandom_range(0, 3)) step();
      end
      drain();
    end

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
